// File: rtl/mem_wb_forward_source_pkg.sv
// Shared types and constants for the EX/MEM and MEM/WB forwarding source.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_wb_forward_source_pkg;

    // Opcodes that select a data-memory access
    localparam logic [6:0] OP_MEMORY_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_MEMORY_STORE = 7'b0100011;

    // Memory access sequencer states
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // EX/MEM pipeline register contents
    typedef struct packed {
        logic [4:0]  rd;
        logic        regwrite;
        logic        memtoreg;
        logic        store;
        logic [31:0] alu_result;
        logic [31:0] store_data;
    } ex_mem_t;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic [4:0]  rd;
        logic        regwrite;
        logic [31:0] result;
    } mem_wb_t;

    // x0 is hardwired to zero, so it is never a legal writeback target
    function automatic logic rd_writable(input logic [4:0] rd);
        return rd != 5'd0;
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Sequences one data-memory access through a ready handshake with a bounded wait.
// Latency: completes in the cycle mem_ready is seen, or after MAX_WAIT wait cycles at most.
// Backpressure: mem_stall freezes the pipe while an access is outstanding and not yet done.
module mem_access_fsm
    import mem_wb_forward_source_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic mem_ready,
    output logic mem_stall,
    output logic timeout_fire,
    output logic mem_timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    mem_state_t    state_q;
    logic [CW-1:0] wait_cnt_q;

    // An access that has waited MAX_WAIT cycles is abandoned and treated as complete
    always_comb begin
        timeout_fire = 1'b0;
        if (state_q == WAIT && mem_req && !mem_ready && wait_cnt_q == MAX_CNT) begin
            timeout_fire = 1'b1;
        end
    end

    assign mem_stall = mem_req & ~mem_ready & ~timeout_fire;

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_req && !mem_ready) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= CW'(1);
                    end
                end
                WAIT: begin
                    if (!mem_req || mem_ready) begin
                        // Completed (or nothing left to wait for): back to idle
                        state_q    <= IDLE;
                        wait_cnt_q <= '0;
                    end else if (timeout_fire) begin
                        state_q     <= IDLE;
                        wait_cnt_q  <= '0;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_forward_source.sv
// Owns the EX/MEM and MEM/WB registers that feed the EX forwarding/hazard checker.
// Latency: EX->EX_MEM 1 cycle, EX_MEM->MEM_WB 1 cycle with a zero-wait memory.
// Backpressure: mem_stall holds both registers; EX_stall inserts a bubble into EX_MEM.
module mem_wb_forward_source
    import mem_wb_forward_source_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_valid,
    input  logic [6:0]  EX_opcode,
    input  logic [4:0]  EX_rd,
    input  logic        EX_regwrite,
    input  logic [31:0] EX_ALU_result,
    input  logic [31:0] EX_store_data,
    input  logic        EX_stall,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_stall,
    output logic        mem_timeout,
    output logic [4:0]  EX_MEM_rd,
    output logic        EX_MEM_regwrite,
    output logic        EX_MEM_memtoreg,
    output logic [31:0] EX_MEM_ALU_result,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regwrite,
    output logic [31:0] MEM_WB_result
);

    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;
    logic    timeout_fire;
    logic    is_load, is_store;

    // Decode the EX instruction; a stalled or invalid slot becomes a bubble
    always_comb begin
        ex_mem_d = '0;
        is_load  = (EX_opcode == OP_MEMORY_LOAD);
        is_store = (EX_opcode == OP_MEMORY_STORE);
        if (EX_valid && !EX_stall) begin
            ex_mem_d.rd         = EX_rd;
            ex_mem_d.memtoreg   = is_load;
            ex_mem_d.store      = is_store;
            ex_mem_d.regwrite   = EX_regwrite & ~is_store & rd_writable(EX_rd);
            ex_mem_d.alu_result = EX_ALU_result;
            ex_mem_d.store_data = EX_store_data;
        end
    end

    // EX/MEM register; holds while a memory access is outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else if (!mem_stall) begin
            ex_mem_q <= ex_mem_d;
        end
    end

    // Writeback value: load data (zero if the access was abandoned) or ALU result
    always_comb begin
        mem_wb_d          = '0;
        mem_wb_d.rd       = ex_mem_q.rd;
        mem_wb_d.regwrite = ex_mem_q.regwrite;
        if (ex_mem_q.memtoreg) begin
            mem_wb_d.result = timeout_fire ? 32'd0 : mem_rdata;
        end else begin
            mem_wb_d.result = ex_mem_q.alu_result;
        end
    end

    // MEM/WB register; holding it re-presents the same write, which is harmless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_q <= '0;
        end else if (!mem_stall) begin
            mem_wb_q <= mem_wb_d;
        end
    end

    // Memory interface is driven straight from EX/MEM so it stays stable while waiting
    assign mem_req   = ex_mem_q.memtoreg | ex_mem_q.store;
    assign mem_we    = ex_mem_q.store;
    assign mem_addr  = ex_mem_q.alu_result;
    assign mem_wdata = ex_mem_q.store_data;

    mem_access_fsm #(
        .MAX_WAIT (MAX_WAIT)
    ) u_mem_access_fsm (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .mem_stall    (mem_stall),
        .timeout_fire (timeout_fire),
        .mem_timeout  (mem_timeout)
    );

    assign EX_MEM_rd         = ex_mem_q.rd;
    assign EX_MEM_regwrite   = ex_mem_q.regwrite;
    assign EX_MEM_memtoreg   = ex_mem_q.memtoreg;
    assign EX_MEM_ALU_result = ex_mem_q.alu_result;
    assign MEM_WB_rd         = mem_wb_q.rd;
    assign MEM_WB_regwrite   = mem_wb_q.regwrite;
    assign MEM_WB_result     = mem_wb_q.result;

endmodule

// File: tb/tb_mem_wb_forward_source.sv
// Directed bench for mem_wb_forward_source with hand-computed expectations.
// Latency: checks sampled 1-2 time units after each rising edge.
// Backpressure: drives mem_ready directly to exercise waits, timeout and reset mid-wait.
module tb_mem_wb_forward_source;

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic        clk;
    logic        rst;
    logic        EX_valid;
    logic [6:0]  EX_opcode;
    logic [4:0]  EX_rd;
    logic        EX_regwrite;
    logic [31:0] EX_ALU_result;
    logic [31:0] EX_store_data;
    logic        EX_stall;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_stall;
    logic        mem_timeout;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_regwrite;
    logic        EX_MEM_memtoreg;
    logic [31:0] EX_MEM_ALU_result;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_regwrite;
    logic [31:0] MEM_WB_result;

    int errors = 0;
    int checks = 0;
    int stall_cnt;

    mem_wb_forward_source #(
        .MAX_WAIT (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .EX_valid          (EX_valid),
        .EX_opcode         (EX_opcode),
        .EX_rd             (EX_rd),
        .EX_regwrite       (EX_regwrite),
        .EX_ALU_result     (EX_ALU_result),
        .EX_store_data     (EX_store_data),
        .EX_stall          (EX_stall),
        .mem_ready         (mem_ready),
        .mem_rdata         (mem_rdata),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_stall         (mem_stall),
        .mem_timeout       (mem_timeout),
        .EX_MEM_rd         (EX_MEM_rd),
        .EX_MEM_regwrite   (EX_MEM_regwrite),
        .EX_MEM_memtoreg   (EX_MEM_memtoreg),
        .EX_MEM_ALU_result (EX_MEM_ALU_result),
        .MEM_WB_rd         (MEM_WB_rd),
        .MEM_WB_regwrite   (MEM_WB_regwrite),
        .MEM_WB_result     (MEM_WB_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [6:0] op, input logic [4:0] rd,
                          input logic rw, input logic [31:0] alu, input logic [31:0] sd);
        EX_valid      = v;
        EX_opcode     = op;
        EX_rd         = rd;
        EX_regwrite   = rw;
        EX_ALU_result = alu;
        EX_store_data = sd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run can never hang
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        EX_stall  = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        set_ex(1'b0, 7'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        repeat (2) tick();

        // Reset state
        check("rst_ex_mem_rd", {27'd0, EX_MEM_rd}, 32'd0);
        check("rst_ex_mem_rw", {31'd0, EX_MEM_regwrite}, 32'd0);
        check("rst_mem_wb_res", MEM_WB_result, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_timeout", {31'd0, mem_timeout}, 32'd0);
        rst = 1'b0;

        // ALU op rd=5 -> EX_MEM after 1 clk, MEM_WB after 2
        set_ex(1'b1, OP_ALU, 5'd5, 1'b1, 32'h1234, 32'd0);
        tick();
        check("alu_ex_mem_rd", {27'd0, EX_MEM_rd}, 32'd5);
        check("alu_ex_mem_rw", {31'd0, EX_MEM_regwrite}, 32'd1);
        check("alu_ex_mem_m2r", {31'd0, EX_MEM_memtoreg}, 32'd0);
        check("alu_ex_mem_res", EX_MEM_ALU_result, 32'h1234);
        check("alu_no_req", {31'd0, mem_req}, 32'd0);
        set_ex(1'b0, 7'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        tick();
        check("alu_mem_wb_rd", {27'd0, MEM_WB_rd}, 32'd5);
        check("alu_mem_wb_rw", {31'd0, MEM_WB_regwrite}, 32'd1);
        check("alu_mem_wb_res", MEM_WB_result, 32'h1234);
        check("alu_bubble_rw", {31'd0, EX_MEM_regwrite}, 32'd0);

        // ALU op to x0 never writes
        set_ex(1'b1, OP_ALU, 5'd0, 1'b1, 32'h55, 32'd0);
        tick();
        check("x0_ex_mem_rw", {31'd0, EX_MEM_regwrite}, 32'd0);
        set_ex(1'b0, 7'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        tick();
        check("x0_mem_wb_rw", {31'd0, MEM_WB_regwrite}, 32'd0);
        check("x0_mem_wb_res", MEM_WB_result, 32'h55);

        // Load rd=7 with three not-ready cycles; ALU op rd=9 waits behind it
        set_ex(1'b1, OP_LOAD, 5'd7, 1'b1, 32'h100, 32'd0);
        tick();
        check("ld_m2r", {31'd0, EX_MEM_memtoreg}, 32'd1);
        check("ld_req", {31'd0, mem_req}, 32'd1);
        check("ld_we", {31'd0, mem_we}, 32'd0);
        check("ld_addr", mem_addr, 32'h100);
        set_ex(1'b1, OP_ALU, 5'd9, 1'b1, 32'h99, 32'd0);
        stall_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            mem_rdata = (k == 3) ? 32'hDEADBEEF : 32'd0;
            #1;
            if (mem_stall) stall_cnt++;
            check("ld_hold_rd", {27'd0, EX_MEM_rd}, 32'd7);
            check("ld_hold_addr", mem_addr, 32'h100);
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        check("ld_stall_cycles", stall_cnt, 32'd3);
        check("ld_mem_wb_rd", {27'd0, MEM_WB_rd}, 32'd7);
        check("ld_mem_wb_res", MEM_WB_result, 32'hDEADBEEF);
        check("ld_next_rd", {27'd0, EX_MEM_rd}, 32'd9);
        set_ex(1'b0, 7'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        tick();
        check("ld_next_wb_rd", {27'd0, MEM_WB_rd}, 32'd9);
        check("ld_next_wb_res", MEM_WB_result, 32'h99);

        // EX_stall: bubble into EX_MEM, MEM_WB still advances from EX_MEM
        set_ex(1'b1, OP_ALU, 5'd3, 1'b1, 32'h33, 32'd0);
        tick();
        set_ex(1'b1, OP_ALU, 5'd4, 1'b1, 32'h44, 32'd0);
        EX_stall = 1'b1;
        tick();
        EX_stall = 1'b0;
        check("exst_ex_mem_rw", {31'd0, EX_MEM_regwrite}, 32'd0);
        check("exst_ex_mem_m2r", {31'd0, EX_MEM_memtoreg}, 32'd0);
        check("exst_ex_mem_rd", {27'd0, EX_MEM_rd}, 32'd0);
        check("exst_mem_wb_rd", {27'd0, MEM_WB_rd}, 32'd3);
        check("exst_mem_wb_res", MEM_WB_result, 32'h33);
        tick();
        check("exst_retry_rd", {27'd0, EX_MEM_rd}, 32'd4);
        check("exst_wb_bubble", {31'd0, MEM_WB_regwrite}, 32'd0);
        set_ex(1'b0, 7'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        tick();

        // Store never acknowledged: 4 stall cycles, then timeout and advance
        set_ex(1'b1, OP_STORE, 5'd11, 1'b1, 32'h200, 32'hCAFE);
        tick();
        check("st_rw", {31'd0, EX_MEM_regwrite}, 32'd0);
        check("st_we", {31'd0, mem_we}, 32'd1);
        check("st_wdata", mem_wdata, 32'hCAFE);
        set_ex(1'b1, OP_ALU, 5'd12, 1'b1, 32'hC, 32'd0);
        stall_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_stall) stall_cnt++;
            if (k < 4) begin
                check("st_hold_addr", mem_addr, 32'h200);
                check("st_no_timeout", {31'd0, mem_timeout}, 32'd0);
            end
            tick();
        end
        check("st_stall_cycles", stall_cnt, 32'd4);
        check("st_timeout", {31'd0, mem_timeout}, 32'd1);
        check("st_next_rd", {27'd0, EX_MEM_rd}, 32'd12);
        check("st_wb_rw", {31'd0, MEM_WB_regwrite}, 32'd0);
        set_ex(1'b0, 7'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        tick();
        check("st_timeout_sticky", {31'd0, mem_timeout}, 32'd1);
        check("st_next_wb_res", MEM_WB_result, 32'hC);

        // Load that times out writes back zero, not the bus value
        set_ex(1'b1, OP_LOAD, 5'd13, 1'b1, 32'h300, 32'd0);
        mem_rdata = 32'hFFFFFFFF;
        tick();
        set_ex(1'b0, 7'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        stall_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_stall) stall_cnt++;
            tick();
        end
        mem_rdata = 32'd0;
        check("ldto_stall_cycles", stall_cnt, 32'd4);
        check("ldto_wb_rd", {27'd0, MEM_WB_rd}, 32'd13);
        check("ldto_wb_res", MEM_WB_result, 32'd0);

        // Reset in the middle of a wait clears everything without a clock edge
        set_ex(1'b1, OP_LOAD, 5'd14, 1'b1, 32'h400, 32'd0);
        tick();
        set_ex(1'b0, 7'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        tick();
        check("rstw_in_wait", {31'd0, mem_stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstw_req", {31'd0, mem_req}, 32'd0);
        check("rstw_stall", {31'd0, mem_stall}, 32'd0);
        check("rstw_timeout", {31'd0, mem_timeout}, 32'd0);
        check("rstw_ex_mem_rd", {27'd0, EX_MEM_rd}, 32'd0);
        check("rstw_addr", mem_addr, 32'd0);
        check("rstw_wb_res", MEM_WB_result, 32'd0);
        check("rstw_wb_rd", {27'd0, MEM_WB_rd}, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check("rstw_no_retry", {31'd0, mem_req}, 32'd0);
        check("rstw_no_stall", {31'd0, mem_stall}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
